// File: rtl/sfg_pkg.sv
// Shared constants, mode codes, FSM states and frame indexing for the scroll frame engine.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sfg_pkg;

    localparam int ROWS    = 5;
    localparam int COLS    = 7;
    localparam int FRAME_W = ROWS * COLS;

    localparam logic [1:0] MODE_PAUSE   = 2'b00;
    localparam logic [1:0] MODE_LEFT    = 2'b01;
    localparam logic [1:0] MODE_RIGHT   = 2'b10;
    localparam logic [1:0] MODE_RESTART = 2'b11;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bit position of the LED at zero-based row r, column c in the flat frame.
    function automatic int fidx(input int r, input int c);
        return r * COLS + c;
    endfunction

endpackage

// File: rtl/msg_col_rom.sv
// Message column ROM: maps a message index to the 5 LED bits of that column (bit r = row r+1).
// Latency: purely combinational, no registers.
// Backpressure: none; the output is valid for whatever index is presented.
module msg_col_rom #(
    parameter int MSG_LEN  = 24,
    parameter int ROM_TEST = 0
) (
    input  logic [$clog2(MSG_LEN)-1:0] idx,
    output logic [4:0]                 col
);

    logic [31:0] iv;

    assign iv = 32'(idx);

    // Test content is a ramp of the index; production content spells "HELO" with blank separators.
    always_comb begin
        col = 5'h00;
        if (ROM_TEST != 0) begin
            col = 5'(iv % 32);
        end else begin
            case (iv)
                1:       col = 5'h1F;
                2:       col = 5'h04;
                3:       col = 5'h04;
                4:       col = 5'h04;
                5:       col = 5'h1F;
                7:       col = 5'h1F;
                8:       col = 5'h15;
                9:       col = 5'h15;
                10:      col = 5'h15;
                11:      col = 5'h11;
                13:      col = 5'h1F;
                14:      col = 5'h10;
                15:      col = 5'h10;
                16:      col = 5'h10;
                17:      col = 5'h10;
                19:      col = 5'h0E;
                20:      col = 5'h11;
                21:      col = 5'h11;
                22:      col = 5'h11;
                23:      col = 5'h0E;
                default: col = 5'h00;
            endcase
        end
    end

endmodule

// File: rtl/scroll_frame_gen.sv
// Scrolling message frame engine: keeps a 7-column window into the message ROM, scrolled by the mode switches.
// Latency: full frame valid 7 edges after reset/restart; a switch change acts on the 3rd edge; shifts every DIV cycles.
// Backpressure: none; the scan driver samples frame continuously and frame_upd flags each change.
module scroll_frame_gen
    import sfg_pkg::*;
#(
    parameter int DIV      = 10,
    parameter int MSG_LEN  = 24,
    parameter int ROM_TEST = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ch0,
    input  logic                       ch1,
    output logic [FRAME_W-1:0]         frame,
    output logic                       frame_valid,
    output logic                       frame_upd,
    output logic [$clog2(MSG_LEN)-1:0] pos
);

    localparam int PW = $clog2(MSG_LEN);
    localparam int CW = $clog2(DIV);

    // Two-flop synchronizer plus one history flop for restart edge detection.
    logic [1:0] sync_q1;
    logic [1:0] mode_s;
    logic [1:0] mode_prev;
    logic       restart_entry;

    state_t                         state_q, state_d;
    logic [2:0]                     k_q, k_d;
    logic [PW-1:0]                  pos_q, pos_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [COLS-1:0][ROWS-1:0]      cols_q, cols_d;
    logic                           valid_q, valid_d;
    logic                           upd_q, upd_d;

    logic          tick;
    logic [PW-1:0] pos_inc;
    logic [PW-1:0] pos_dec;
    logic [PW-1:0] rom_idx;
    logic [4:0]    rom_col;

    // (a + b) mod MSG_LEN; a < MSG_LEN and b <= 7 < MSG_LEN, so one subtract suffices.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input logic [2:0] b);
        int s;
        s = int'(a) + int'(b);
        if (s >= MSG_LEN) begin
            s = s - MSG_LEN;
        end
        return PW'(s);
    endfunction

    assign restart_entry = (mode_s == MODE_RESTART) && (mode_prev != MODE_RESTART);
    assign tick          = (state_q == RUN) && (cnt_q == CW'(DIV - 1));
    assign pos_inc       = wrap_add(pos_q, 3'd1);
    assign pos_dec       = (pos_q == '0) ? PW'(MSG_LEN - 1) : pos_q - 1'b1;

    // One ROM port serves every write: load column k, new right column on LEFT, new left column on RIGHT.
    always_comb begin
        rom_idx = wrap_add(pos_q, k_q);
        if (state_q == RUN) begin
            if (mode_s == MODE_LEFT) begin
                rom_idx = wrap_add(pos_q, 3'd7);
            end else begin
                rom_idx = pos_dec;
            end
        end
    end

    msg_col_rom #(
        .MSG_LEN  (MSG_LEN),
        .ROM_TEST (ROM_TEST)
    ) u_rom (
        .idx (rom_idx),
        .col (rom_col)
    );

    // Mode synchronizer and restart history.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q1   <= 2'b00;
            mode_s    <= 2'b00;
            mode_prev <= 2'b00;
        end else begin
            sync_q1   <= {ch1, ch0};
            mode_s    <= sync_q1;
            mode_prev <= mode_s;
        end
    end

    // Next-state: restart beats tick; LOAD fills one column per cycle, RUN shifts on tick.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        cols_d  = cols_q;
        valid_d = valid_q;
        upd_d   = 1'b0;
        if (restart_entry) begin
            state_d = LOAD;
            k_d     = 3'd0;
            pos_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    cols_d[k_q] = rom_col;
                    cnt_d       = '0;
                    valid_d     = 1'b0;
                    if (k_q == 3'd6) begin
                        state_d = RUN;
                        k_d     = 3'd0;
                        valid_d = 1'b1;
                        upd_d   = 1'b1;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
                RUN: begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                    if (tick) begin
                        if (mode_s == MODE_LEFT) begin
                            pos_d = pos_inc;
                            for (int c = 0; c < COLS - 1; c++) begin
                                cols_d[c] = cols_q[c+1];
                            end
                            cols_d[COLS-1] = rom_col;
                            upd_d          = 1'b1;
                        end else if (mode_s == MODE_RIGHT) begin
                            pos_d = pos_dec;
                            for (int c = 1; c < COLS; c++) begin
                                cols_d[c] = cols_q[c-1];
                            end
                            cols_d[0] = rom_col;
                            upd_d     = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = LOAD;
                    k_d     = 3'd0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= LOAD;
            k_q     <= 3'd0;
            pos_q   <= '0;
            cnt_q   <= '0;
            cols_q  <= '0;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            cols_q  <= cols_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
        end
    end

    // Flatten the column store into row-major frame order.
    always_comb begin
        frame = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                frame[fidx(r, c)] = cols_q[c][r];
            end
        end
    end

    assign frame_valid = valid_q;
    assign frame_upd   = upd_q;
    assign pos         = pos_q;

endmodule

// File: tb/tb_scroll_frame_gen.sv
module tb_scroll_frame_gen;

    logic        CLK;
    logic        RST;
    logic        ch0;
    logic        ch1;
    logic [34:0] frame;
    logic        frame_valid;
    logic        frame_upd;
    logic [3:0]  pos;

    int checks;
    int failures;
    int upd_cnt;

    scroll_frame_gen #(
        .DIV      (4),
        .MSG_LEN  (10),
        .ROM_TEST (1)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ch0         (ch0),
        .ch1         (ch1),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_upd   (frame_upd),
        .pos         (pos)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges, sampling at each following falling edge and counting update pulses.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (frame_upd === 1'b1) upd_cnt++;
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        ch1 = m[1];
        ch0 = m[0];
    endtask

    // Expected frame for a window starting at message index p with the ramp ROM (column i = i).
    function automatic logic [34:0] win(input int p);
        logic [34:0] f;
        logic [4:0]  v;
        f = '0;
        for (int c = 0; c < 7; c++) begin
            v = 5'((p + c) % 10);
            for (int r = 0; r < 5; r++) begin
                f[r*7+c] = v[r];
            end
        end
        return f;
    endfunction

    // Expected frame for an explicit list of column values.
    function automatic logic [34:0] cols7(input int c0, input int c1, input int c2, input int c3,
                                          input int c4, input int c5, input int c6);
        logic [34:0] f;
        logic [4:0]  v;
        int          vals[7];
        vals = '{c0, c1, c2, c3, c4, c5, c6};
        f = '0;
        for (int c = 0; c < 7; c++) begin
            v = 5'(vals[c]);
            for (int r = 0; r < 5; r++) begin
                f[r*7+c] = v[r];
            end
        end
        return f;
    endfunction

    initial begin
        logic [34:0] held;
        checks   = 0;
        failures = 0;
        upd_cnt  = 0;
        RST = 1'b1;
        set_mode(2'b00);

        // 1. Reset and initial load.
        run(3);
        chk("rst_frame", 64'(frame), 64'(0));
        chk("rst_valid", 64'(frame_valid), 64'(0));
        chk("rst_upd", 64'(frame_upd), 64'(0));
        chk("rst_pos", 64'(pos), 64'(0));
        RST = 1'b0;
        upd_cnt = 0;
        run(6);
        chk("load_valid_early", 64'(frame_valid), 64'(0));
        run(1);
        chk("load_valid", 64'(frame_valid), 64'(1));
        chk("load_frame", 64'(frame), 64'(cols7(0, 1, 2, 3, 4, 5, 6)));
        chk("load_pos", 64'(pos), 64'(0));
        chk("load_upd", 64'(upd_cnt), 64'(1));

        // 2. Left scroll: first tick on 4th edge after the switch, then every 4 cycles.
        set_mode(2'b01);
        for (int j = 1; j <= 4; j++) begin
            upd_cnt = 0;
            run(4);
            chk("left_upd", 64'(upd_cnt), 64'(1));
            chk("left_pos", 64'(pos), 64'(j));
        end
        chk("left_frame4", 64'(frame), 64'(cols7(4, 5, 6, 7, 8, 9, 0)));
        run(20);
        chk("left_pos9", 64'(pos), 64'(9));
        run(4);
        chk("left_wrap_pos", 64'(pos), 64'(0));
        chk("left_wrap_frame", 64'(frame), 64'(win(0)));

        // 3. Right scroll with wrap below zero.
        set_mode(2'b10);
        upd_cnt = 0;
        run(4);
        chk("right_pos9", 64'(pos), 64'(9));
        chk("right_frame9", 64'(frame), 64'(cols7(9, 0, 1, 2, 3, 4, 5)));
        chk("right_upd", 64'(upd_cnt), 64'(1));
        run(4);
        chk("right_pos8", 64'(pos), 64'(8));
        chk("right_frame8", 64'(frame), 64'(win(8)));

        // 4. Pause at pos 3, then resume left.
        set_mode(2'b01);
        run(20);
        chk("pre_pause_pos", 64'(pos), 64'(3));
        held = frame;
        set_mode(2'b00);
        upd_cnt = 0;
        run(20);
        chk("pause_pos", 64'(pos), 64'(3));
        chk("pause_frame", 64'(frame), 64'(win(3)));
        chk("pause_frame_held", 64'(frame), 64'(held));
        chk("pause_valid", 64'(frame_valid), 64'(1));
        chk("pause_upd", 64'(upd_cnt), 64'(0));
        set_mode(2'b01);
        run(4);
        chk("resume_upd", 64'(upd_cnt), 64'(1));
        chk("resume_pos", 64'(pos), 64'(4));

        // 5. Restart from pos 5 and hold 11.
        run(4);
        chk("pre_restart_pos", 64'(pos), 64'(5));
        set_mode(2'b11);
        run(2);
        chk("restart_valid_e2", 64'(frame_valid), 64'(1));
        chk("restart_pos_e2", 64'(pos), 64'(5));
        run(1);
        chk("restart_valid_e3", 64'(frame_valid), 64'(0));
        chk("restart_pos_e3", 64'(pos), 64'(0));
        upd_cnt = 0;
        run(6);
        chk("reload_valid_early", 64'(frame_valid), 64'(0));
        run(1);
        chk("reload_valid", 64'(frame_valid), 64'(1));
        chk("reload_frame", 64'(frame), 64'(win(0)));
        chk("reload_upd", 64'(upd_cnt), 64'(1));
        upd_cnt = 0;
        run(20);
        chk("hold11_pos", 64'(pos), 64'(0));
        chk("hold11_valid", 64'(frame_valid), 64'(1));
        chk("hold11_upd", 64'(upd_cnt), 64'(0));
        chk("hold11_frame", 64'(frame), 64'(win(0)));

        // 6a. Reset during load at k=3.
        set_mode(2'b00);
        run(3);
        set_mode(2'b11);
        run(6);
        chk("mid_load_valid", 64'(frame_valid), 64'(0));
        RST = 1'b1;
        set_mode(2'b00);
        run(1);
        chk("rst_load_frame", 64'(frame), 64'(0));
        chk("rst_load_pos", 64'(pos), 64'(0));
        chk("rst_load_valid", 64'(frame_valid), 64'(0));
        RST = 1'b0;
        upd_cnt = 0;
        run(6);
        chk("rst_load_reload_early", 64'(frame_valid), 64'(0));
        run(1);
        chk("rst_load_reload_valid", 64'(frame_valid), 64'(1));
        chk("rst_load_reload_frame", 64'(frame), 64'(win(0)));

        // 6b. Reset during RUN at pos 7.
        set_mode(2'b01);
        run(28);
        chk("run_pos7", 64'(pos), 64'(7));
        chk("run_frame7", 64'(frame), 64'(win(7)));
        RST = 1'b1;
        set_mode(2'b00);
        run(1);
        chk("rst_run_frame", 64'(frame), 64'(0));
        chk("rst_run_pos", 64'(pos), 64'(0));
        chk("rst_run_valid", 64'(frame_valid), 64'(0));
        RST = 1'b0;
        upd_cnt = 0;
        run(7);
        chk("rst_run_reload_valid", 64'(frame_valid), 64'(1));
        chk("rst_run_reload_frame", 64'(frame), 64'(win(0)));
        chk("rst_run_reload_upd", 64'(upd_cnt), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
